// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register: main entry plus one-entry skid buffer,
// synchronous flush, bubble gating of outputs and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned REG_W       = 3,
  parameter int unsigned CTRL_W      = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          ZERO_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rdval_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rdval_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdval;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;
  payload_t         in_pl;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             deliver;

  assign in_pl = '{ctrl: control_in, alu: alu_in, rdval: rdval_in, rd: rd_in, imm: imm_in};

  // Handshake decode uses registered state only, so in_ready never depends on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_pl;
        end
      end
      ST_ONE: begin
        if (deliver && accept) begin
          main_d = in_pl;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_pl;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush discards anything loaded this cycle; the main entry keeps its old data.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Bubble gating is folded into the main entry so outputs stay pure flop outputs.
    if (state_d == ST_EMPTY) begin
      main_d.ctrl = '0;
      if (ZERO_BUBBLE) begin
        main_d.alu   = '0;
        main_d.rdval = '0;
        main_d.rd    = '0;
        main_d.imm   = '0;
      end
    end

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign control_out = main_q.ctrl;
  assign alu_out     = main_q.alu;
  assign rdval_out   = main_q.rdval;
  assign rd_out      = main_q.rd;
  assign imm_out     = main_q.imm;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default, zero-bubble and 4-bit-counter
// instances share one stimulus stream and are checked against hand-computed rows.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] control_in = '0;
  logic [7:0]  alu_in = '0;
  logic [7:0]  rdval_in = '0;
  logic [2:0]  rd_in = '0;
  logic [7:0]  imm_in = '0;

  logic        d_in_ready, d_out_valid, z_in_ready, z_out_valid, s_in_ready, s_out_valid;
  logic [15:0] d_ctrl, z_ctrl, s_ctrl, d_stall, z_stall;
  logic [7:0]  d_alu, d_rdval, d_imm, z_alu, z_rdval, z_imm, s_alu, s_rdval, s_imm;
  logic [2:0]  d_rd, z_rd, s_rd;
  logic [3:0]  s_stall;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .control_in(control_in), .alu_in(alu_in), .rdval_in(rdval_in), .rd_in(rd_in), .imm_in(imm_in),
    .out_valid(d_out_valid), .out_ready(out_ready), .control_out(d_ctrl), .alu_out(d_alu),
    .rdval_out(d_rdval), .rd_out(d_rd), .imm_out(d_imm), .stall_cnt(d_stall)
  );

  pipe_stage_reg #(.ZERO_BUBBLE(1'b1)) u_zb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .control_in(control_in), .alu_in(alu_in), .rdval_in(rdval_in), .rd_in(rd_in), .imm_in(imm_in),
    .out_valid(z_out_valid), .out_ready(out_ready), .control_out(z_ctrl), .alu_out(z_alu),
    .rdval_out(z_rdval), .rd_out(z_rd), .imm_out(z_imm), .stall_cnt(z_stall)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .control_in(control_in), .alu_in(alu_in), .rdval_in(rdval_in), .rd_in(rd_in), .imm_in(imm_in),
    .out_valid(s_out_valid), .out_ready(out_ready), .control_out(s_ctrl), .alu_out(s_alu),
    .rdval_out(s_rdval), .rd_out(s_rd), .imm_out(s_imm), .stall_cnt(s_stall)
  );

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [7:0] din;
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_alu;
    int         e_stall;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Every payload field is derived from the alu byte so one column identifies it.
  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [7:0] d);
    in_valid   = iv;
    out_ready  = ordy;
    flush      = fl;
    alu_in     = d;
    control_in = {d, 8'h5A};
    rdval_in   = d ^ 8'hFF;
    rd_in      = d[2:0];
    imm_in     = d + 8'h03;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 32'(d_out_valid), 32'd0);
    chk({tag, " in_ready"}, 32'(d_in_ready), 32'd1);
    chk({tag, " alu"}, 32'(d_alu), 32'd0);
    chk({tag, " ctrl"}, 32'(d_ctrl), 32'd0);
    chk({tag, " rdval"}, 32'(d_rdval), 32'd0);
    chk({tag, " imm"}, 32'(d_imm), 32'd0);
    chk({tag, " stall"}, 32'(d_stall), 32'd0);
    chk({tag, " sat stall"}, 32'(s_stall), 32'd0);
    chk({tag, " zb stall"}, 32'(z_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ea, zb_a;
    logic [15:0] ec;
    string       t;

    // Streaming, back-pressure, flush and drain rows: {iv, ordy, fl, din} -> {ov, ir, alu, stall}
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 8'h01, 0});
    for (int k = 2; k <= 8; k++)
      vq.push_back('{1'b1, 1'b1, 1'b0, 8'(k), 1'b1, 1'b1, 8'(k), 0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h08, 0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'h11, 1});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'h11, 2});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'h11, 3});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h22, 3});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h33, 3});
    vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 8'h44, 3});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'h44, 4});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h44, 5});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'h44, 5});
    vq.push_back('{1'b1, 1'b0, 1'b0, 8'h88, 1'b1, 1'b1, 8'h88, 5});
    vq.push_back('{1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h88, 6});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 8'hAA, 6});
    vq.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hAA, 6});
    vq.push_back('{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 6});
    vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 6});

    // Asynchronous reset, checked between edges.
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    tick();
    tick();
    chk_zero("reset held");
    reset_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].iv, vq[i].ordy, vq[i].fl, vq[i].din);
      tick();
      t    = $sformatf("row%0d", i);
      ea   = vq[i].e_alu;
      ec   = vq[i].e_ov ? {ea, 8'h5A} : 16'h0000;
      zb_a = vq[i].e_ov ? ea : 8'h00;
      chk({t, " out_valid"}, 32'(d_out_valid), 32'(vq[i].e_ov));
      chk({t, " in_ready"}, 32'(d_in_ready), 32'(vq[i].e_ir));
      chk({t, " alu"}, 32'(d_alu), 32'(ea));
      chk({t, " ctrl"}, 32'(d_ctrl), 32'(ec));
      chk({t, " rdval"}, 32'(d_rdval), 32'(ea ^ 8'hFF));
      chk({t, " rd"}, 32'(d_rd), 32'(ea[2:0]));
      chk({t, " imm"}, 32'(d_imm), 32'(8'(ea + 8'h03)));
      chk({t, " stall"}, 32'(d_stall), 32'(vq[i].e_stall));
      chk({t, " zb out_valid"}, 32'(z_out_valid), 32'(vq[i].e_ov));
      chk({t, " zb alu"}, 32'(z_alu), 32'(zb_a));
      chk({t, " zb ctrl"}, 32'(z_ctrl), 32'(ec));
      chk({t, " zb rdval"}, 32'(z_rdval), vq[i].e_ov ? 32'(ea ^ 8'hFF) : 32'd0);
      chk({t, " sat stall"}, 32'(s_stall), 32'((vq[i].e_stall > 15) ? 15 : vq[i].e_stall));
    end

    // Fill to FULL, then pulse reset between edges.
    drive(1'b1, 1'b0, 1'b0, 8'hB1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'hB2);
    tick();
    chk("midreset full in_ready", 32'(d_in_ready), 32'd0);
    chk("midreset full stall", 32'(d_stall), 32'd7);
    #3 reset_n = 1'b0;
    #1 chk_zero("midreset");
    #2 reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'hC1);
    tick();
    chk("post-reset out_valid", 32'(d_out_valid), 32'd1);
    chk("post-reset alu", 32'(d_alu), 32'hC1);
    chk("post-reset stall", 32'(d_stall), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("post-reset drain out_valid", 32'(d_out_valid), 32'd0);

    // Saturation: 20 stalled cycles against the 4-bit counter.
    drive(1'b1, 1'b0, 1'b0, 8'hD1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("sat cyc%0d", c), 32'(s_stall), 32'((c > 15) ? 15 : c));
    end
    chk("sat wide stall", 32'(d_stall), 32'd20);
    chk("sat out_valid", 32'(s_out_valid), 32'd1);
    chk("sat alu", 32'(s_alu), 32'hD1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
